// File: rtl/tlp_rx_dispatcher.sv
// rtl/tlp_rx_dispatcher.sv - credit-gated TLP class dispatcher with single skid entry; optional TLP_RX_STATS_EN counters

module tlp_rx_credit #(
    parameter int MAX = 8,
    parameter int W   = $clog2(MAX + 1)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         take,
    input  logic         ret,
    output logic [W-1:0] credit,
    output logic         avail,
    output logic         err_pulse
);

    assign avail     = (credit != '0);
    assign err_pulse = ret && (credit == W'(MAX));

    // Simultaneous take and return cancel; a return at the ceiling is held off
    always_ff @(posedge clk) begin
        if (rst) begin
            credit <= W'(MAX);
        end else if (take && !ret) begin
            credit <= credit - W'(1);
        end else if (ret && !take && (credit != W'(MAX))) begin
            credit <= credit + W'(1);
        end
    end

endmodule

module tlp_rx_dispatcher #(
    parameter int DATA_W      = 1024,
    parameter int P_CREDITS   = 8,
    parameter int NP_CREDITS  = 8,
    parameter int CPL_CREDITS = 16
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               tlp_valid_i,
    output logic                               tlp_ready_o,
    input  logic [DATA_W-1:0]                  tlp_data_i,
    output logic [DATA_W-1:0]                  tlp_data_o,
    output logic                               p_valid_o,
    input  logic                               p_ready_i,
    output logic                               np_valid_o,
    input  logic                               np_ready_i,
    output logic                               cpl_valid_o,
    input  logic                               cpl_ready_i,
    input  logic                               p_credit_ret_i,
    input  logic                               np_credit_ret_i,
    input  logic                               cpl_credit_ret_i,
    output logic [$clog2(P_CREDITS+1)-1:0]     p_credit_o,
    output logic [$clog2(NP_CREDITS+1)-1:0]    np_credit_o,
    output logic [$clog2(CPL_CREDITS+1)-1:0]   cpl_credit_o,
    output logic                               drop_o,
    output logic                               credit_err_o
`ifdef TLP_RX_STATS_EN
    ,
    output logic [31:0]                        p_cnt_o,
    output logic [31:0]                        np_cnt_o,
    output logic [31:0]                        cpl_cnt_o,
    output logic [31:0]                        drop_cnt_o
`endif
);

    localparam logic [0:0] ST_EMPTY = 1'b0;
    localparam logic [0:0] ST_FULL  = 1'b1;

    localparam logic [1:0] CLS_P    = 2'd0;
    localparam logic [1:0] CLS_NP   = 2'd1;
    localparam logic [1:0] CLS_CPL  = 2'd2;
    localparam logic [1:0] CLS_DROP = 2'd3;

    logic [0:0] state;
    logic [1:0] cls_q;
    logic [1:0] in_cls;
    logic       out_fire;
    logic       can_take;
    logic       accept;
    logic       acc_fwd;
    logic       p_avail, np_avail, cpl_avail;
    logic       p_err, np_err, cpl_err;

    // Decode fmt/type byte of the incoming header into a dispatch class
    always_comb begin
        in_cls = CLS_DROP;
        case (tlp_data_i[607:600])
            8'h40:        in_cls = CLS_P;
            8'h00:        in_cls = CLS_NP;
            8'h0A, 8'h4A: in_cls = CLS_CPL;
            default:      in_cls = CLS_DROP;
        endcase
    end

    assign out_fire = (state == ST_FULL) &&
                      ((p_valid_o && p_ready_i) ||
                       (np_valid_o && np_ready_i) ||
                       (cpl_valid_o && cpl_ready_i));
    assign can_take = (state == ST_EMPTY) || out_fire;

    // Forwarded classes need a credit; discarded beats only need the slot to be draining
    always_comb begin
        tlp_ready_o = 1'b0;
        case (in_cls)
            CLS_P:   tlp_ready_o = can_take && p_avail;
            CLS_NP:  tlp_ready_o = can_take && np_avail;
            CLS_CPL: tlp_ready_o = can_take && cpl_avail;
            default: tlp_ready_o = can_take;
        endcase
    end

    assign accept  = tlp_valid_i && tlp_ready_o;
    assign acc_fwd = accept && (in_cls != CLS_DROP);

    tlp_rx_credit #(.MAX(P_CREDITS)) u_p_credit (
        .clk       (clk),
        .rst       (rst),
        .take      (acc_fwd && (in_cls == CLS_P)),
        .ret       (p_credit_ret_i),
        .credit    (p_credit_o),
        .avail     (p_avail),
        .err_pulse (p_err)
    );

    tlp_rx_credit #(.MAX(NP_CREDITS)) u_np_credit (
        .clk       (clk),
        .rst       (rst),
        .take      (acc_fwd && (in_cls == CLS_NP)),
        .ret       (np_credit_ret_i),
        .credit    (np_credit_o),
        .avail     (np_avail),
        .err_pulse (np_err)
    );

    tlp_rx_credit #(.MAX(CPL_CREDITS)) u_cpl_credit (
        .clk       (clk),
        .rst       (rst),
        .take      (acc_fwd && (in_cls == CLS_CPL)),
        .ret       (cpl_credit_ret_i),
        .credit    (cpl_credit_o),
        .avail     (cpl_avail),
        .err_pulse (cpl_err)
    );

    // Skid entry: load on forwarded accept, free on handshake without refill
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_EMPTY;
            cls_q       <= CLS_DROP;
            tlp_data_o  <= '0;
            p_valid_o   <= 1'b0;
            np_valid_o  <= 1'b0;
            cpl_valid_o <= 1'b0;
        end else if (acc_fwd) begin
            state       <= ST_FULL;
            cls_q       <= in_cls;
            tlp_data_o  <= tlp_data_i;
            p_valid_o   <= (in_cls == CLS_P);
            np_valid_o  <= (in_cls == CLS_NP);
            cpl_valid_o <= (in_cls == CLS_CPL);
        end else if (out_fire) begin
            state       <= ST_EMPTY;
            p_valid_o   <= 1'b0;
            np_valid_o  <= 1'b0;
            cpl_valid_o <= 1'b0;
        end
    end

    // Discard pulse and sticky over-return flag
    always_ff @(posedge clk) begin
        if (rst) begin
            drop_o       <= 1'b0;
            credit_err_o <= 1'b0;
        end else begin
            drop_o <= accept && (in_cls == CLS_DROP);
            if (p_err || np_err || cpl_err) begin
                credit_err_o <= 1'b1;
            end
        end
    end

`ifdef TLP_RX_STATS_EN
    // Per-class forwarded handshake and discard counters, free-running wrap
    always_ff @(posedge clk) begin
        if (rst) begin
            p_cnt_o    <= '0;
            np_cnt_o   <= '0;
            cpl_cnt_o  <= '0;
            drop_cnt_o <= '0;
        end else begin
            if (out_fire && (cls_q == CLS_P))   p_cnt_o   <= p_cnt_o + 32'd1;
            if (out_fire && (cls_q == CLS_NP))  np_cnt_o  <= np_cnt_o + 32'd1;
            if (out_fire && (cls_q == CLS_CPL)) cpl_cnt_o <= cpl_cnt_o + 32'd1;
            if (accept && (in_cls == CLS_DROP)) drop_cnt_o <= drop_cnt_o + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_tlp_rx_dispatcher.sv
// tb/tb_tlp_rx_dispatcher.sv - scoreboard bench for tlp_rx_dispatcher

module tb_tlp_rx_dispatcher;

    localparam int DATA_W = 1024;

    typedef struct {
        int               cls;
        logic [DATA_W-1:0] data;
    } sb_entry_t;

    logic              clk = 1'b0;
    logic              rst;
    logic              tlp_valid_i;
    logic              tlp_ready_o;
    logic [DATA_W-1:0] tlp_data_i;
    logic [DATA_W-1:0] tlp_data_o;
    logic              p_valid_o, np_valid_o, cpl_valid_o;
    logic              p_ready_i, np_ready_i, cpl_ready_i;
    logic              p_credit_ret_i, np_credit_ret_i, cpl_credit_ret_i;
    logic [3:0]        p_credit_o, np_credit_o;
    logic [4:0]        cpl_credit_o;
    logic              drop_o;
    logic              credit_err_o;
`ifdef TLP_RX_STATS_EN
    logic [31:0]       p_cnt_o, np_cnt_o, cpl_cnt_o, drop_cnt_o;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    sb_entry_t sb[$];
    int hs_cnt[3];
    int ret_cnt[3];
    logic [DATA_W-1:0] held;
    logic [7:0] hdr_tab[6];

    always #5 clk = ~clk;

    tlp_rx_dispatcher dut (
        .clk              (clk),
        .rst              (rst),
        .tlp_valid_i      (tlp_valid_i),
        .tlp_ready_o      (tlp_ready_o),
        .tlp_data_i       (tlp_data_i),
        .tlp_data_o       (tlp_data_o),
        .p_valid_o        (p_valid_o),
        .p_ready_i        (p_ready_i),
        .np_valid_o       (np_valid_o),
        .np_ready_i       (np_ready_i),
        .cpl_valid_o      (cpl_valid_o),
        .cpl_ready_i      (cpl_ready_i),
        .p_credit_ret_i   (p_credit_ret_i),
        .np_credit_ret_i  (np_credit_ret_i),
        .cpl_credit_ret_i (cpl_credit_ret_i),
        .p_credit_o       (p_credit_o),
        .np_credit_o      (np_credit_o),
        .cpl_credit_o     (cpl_credit_o),
        .drop_o           (drop_o),
        .credit_err_o     (credit_err_o)
`ifdef TLP_RX_STATS_EN
        ,
        .p_cnt_o          (p_cnt_o),
        .np_cnt_o         (np_cnt_o),
        .cpl_cnt_o        (cpl_cnt_o),
        .drop_cnt_o       (drop_cnt_o)
`endif
    );

    task automatic check(input string tag, input logic [DATA_W-1:0] got, input logic [DATA_W-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got[127:0], exp[127:0]);
        end
    endtask

    function automatic int cls_of(input logic [7:0] hdr);
        case (hdr)
            8'h40:        return 0;
            8'h00:        return 1;
            8'h0A, 8'h4A: return 2;
            default:      return 3;
        endcase
    endfunction

    function automatic logic [DATA_W-1:0] mk(input logic [7:0] hdr);
        logic [DATA_W-1:0] d;
        for (int i = 0; i < DATA_W / 32; i++) d[i*32 +: 32] = $urandom;
        d[607:600] = hdr;
        return d;
    endfunction

    task automatic deliver(input int ch);
        sb_entry_t e;
        if (sb.size() == 0) begin
            check("sb_underflow", 1, 0);
        end else begin
            e = sb.pop_front();
            check("out_cls", ch, e.cls);
            check("out_data", tlp_data_o, e.data);
        end
        hs_cnt[ch]++;
    endtask

    // Observe at the falling edge: handshakes pop, accepts push
    task automatic sample();
        int c;
        @(negedge clk);
        if (!rst) begin
            check("valid_onehot", ($countones({p_valid_o, np_valid_o, cpl_valid_o}) <= 1), 1);
            if (p_valid_o && p_ready_i)     deliver(0);
            if (np_valid_o && np_ready_i)   deliver(1);
            if (cpl_valid_o && cpl_ready_i) deliver(2);
            c = cls_of(tlp_data_i[607:600]);
            if (tlp_valid_i && tlp_ready_o && c != 3) sb.push_back('{c, tlp_data_i});
        end
    endtask

    task automatic advance();
        @(posedge clk);
        #1;
    endtask

    task automatic cyc();
        sample();
        advance();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        hdr_tab = '{8'h40, 8'h00, 8'h0A, 8'h4A, 8'h04, 8'h1F};
        rst = 1'b1; tlp_valid_i = 1'b0; tlp_data_i = '0;
        p_ready_i = 1'b0; np_ready_i = 1'b0; cpl_ready_i = 1'b0;
        p_credit_ret_i = 1'b0; np_credit_ret_i = 1'b0; cpl_credit_ret_i = 1'b0;
        advance(); advance();
        rst = 1'b0;

        sample();
        check("rst_p_credit", p_credit_o, 8);
        check("rst_np_credit", np_credit_o, 8);
        check("rst_cpl_credit", cpl_credit_o, 16);
        check("rst_valids", {p_valid_o, np_valid_o, cpl_valid_o}, 0);
        check("rst_data", tlp_data_o, 0);
        check("rst_drop", drop_o, 0);
        check("rst_err", credit_err_o, 0);
        advance();

        // MWR forwarded, credit consumed and returned
        p_ready_i = 1'b1; tlp_valid_i = 1'b1; tlp_data_i = mk(8'h40);
        sample(); check("mwr_ready", tlp_ready_o, 1); advance();
        tlp_valid_i = 1'b0;
        sample(); check("mwr_valid", p_valid_o, 1); check("mwr_credit_dec", p_credit_o, 7); advance();
        p_credit_ret_i = 1'b1; cyc(); p_credit_ret_i = 1'b0;
        sample(); check("mwr_credit_ret", p_credit_o, 8); advance();

        // Nine MRDs against eight NP credits
        np_ready_i = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tlp_valid_i = 1'b1; tlp_data_i = mk(8'h00);
            sample(); check("mrd_ready", tlp_ready_o, 1); advance();
        end
        tlp_data_i = mk(8'h00);
        for (int i = 0; i < 3; i++) begin
            sample(); check("mrd9_stall", tlp_ready_o, 0); check("np_credit_zero", np_credit_o, 0); advance();
        end
        np_credit_ret_i = 1'b1;
        sample(); check("mrd9_stall_ret", tlp_ready_o, 0); advance();
        np_credit_ret_i = 1'b0;
        sample(); check("mrd9_ready", tlp_ready_o, 1); advance();
        tlp_valid_i = 1'b0;
        sample(); check("np_credit_after9", np_credit_o, 0); advance();
        np_credit_ret_i = 1'b1;
        for (int i = 0; i < 8; i++) cyc();
        np_credit_ret_i = 1'b0;
        sample(); check("np_credit_restored", np_credit_o, 8); advance();

        // CPLD held under backpressure, second CPL stalls behind it
        tlp_valid_i = 1'b1; held = mk(8'h4A); tlp_data_i = held;
        sample(); check("cpld_ready", tlp_ready_o, 1); advance();
        tlp_data_i = mk(8'h0A);
        for (int i = 0; i < 5; i++) begin
            sample();
            check("cpld_hold_valid", cpl_valid_o, 1);
            check("cpld_hold_data", tlp_data_o, held);
            check("cpl_stall", tlp_ready_o, 0);
            advance();
        end
        cpl_ready_i = 1'b1;
        sample(); check("cpl_pass_through", tlp_ready_o, 1); advance();
        tlp_valid_i = 1'b0;
        sample(); check("cpl_credit_dec2", cpl_credit_o, 14); advance();
        cpl_credit_ret_i = 1'b1; cyc(); cyc(); cpl_credit_ret_i = 1'b0;
        sample(); check("cpl_credit_restored", cpl_credit_o, 16); advance();

        // Unsupported type is swallowed
        tlp_valid_i = 1'b1; tlp_data_i = mk(8'h04);
        sample(); check("drop_ready", tlp_ready_o, 1); advance();
        tlp_valid_i = 1'b0;
        sample();
        check("drop_pulse", drop_o, 1);
        check("drop_credits", {p_credit_o, np_credit_o, cpl_credit_o}, {4'd8, 4'd8, 5'd16});
        check("drop_valids", {p_valid_o, np_valid_o, cpl_valid_o}, 0);
`ifdef TLP_RX_STATS_EN
        check("drop_cnt", drop_cnt_o, 1);
        check("p_cnt", p_cnt_o, 1);
        check("np_cnt", np_cnt_o, 9);
        check("cpl_cnt", cpl_cnt_o, 2);
`endif
        advance();
        sample(); check("drop_pulse_end", drop_o, 0); advance();

        // Over-return at the ceiling
        cpl_credit_ret_i = 1'b1; cyc(); cpl_credit_ret_i = 1'b0;
        sample(); check("over_ret_credit", cpl_credit_o, 16); check("over_ret_err", credit_err_o, 1); advance();
        cyc();
        sample(); check("err_sticky", credit_err_o, 1); advance();
        rst = 1'b1; cyc(); rst = 1'b0;
        sample(); check("err_cleared", credit_err_o, 0); advance();

        // Reset while holding a posted TLP
        p_ready_i = 1'b0; tlp_valid_i = 1'b1; tlp_data_i = mk(8'h40);
        cyc();
        tlp_valid_i = 1'b0;
        sample(); check("full_p_valid", p_valid_o, 1); check("full_p_credit", p_credit_o, 7); advance();
        rst = 1'b1; cyc(); rst = 1'b0;
        sb.delete();
        tlp_valid_i = 1'b1; tlp_data_i = mk(8'h40);
        sample();
        check("post_rst_valid", p_valid_o, 0);
        check("post_rst_credit", p_credit_o, 8);
        check("post_rst_ready", tlp_ready_o, 1);
        advance();
        tlp_valid_i = 1'b0; p_ready_i = 1'b1;
        cyc();
        p_credit_ret_i = 1'b1; cyc(); p_credit_ret_i = 1'b0;

        // Random mix with random backpressure and returns
        for (int c = 0; c < 3; c++) begin hs_cnt[c] = 0; ret_cnt[c] = 0; end
        for (int n = 0; n < 60; n++) begin
            logic got;
            got = 1'b0;
            tlp_valid_i = 1'b1;
            tlp_data_i = mk(hdr_tab[$urandom_range(0, 5)]);
            for (int w = 0; w < 80 && !got; w++) begin
                p_ready_i = $urandom_range(0, 1); np_ready_i = $urandom_range(0, 1); cpl_ready_i = $urandom_range(0, 1);
                p_credit_ret_i   = (hs_cnt[0] > ret_cnt[0]) && ($urandom_range(0, 1) == 1);
                np_credit_ret_i  = (hs_cnt[1] > ret_cnt[1]) && ($urandom_range(0, 1) == 1);
                cpl_credit_ret_i = (hs_cnt[2] > ret_cnt[2]) && ($urandom_range(0, 1) == 1);
                if (p_credit_ret_i)   ret_cnt[0]++;
                if (np_credit_ret_i)  ret_cnt[1]++;
                if (cpl_credit_ret_i) ret_cnt[2]++;
                sample();
                got = tlp_ready_o;
                advance();
            end
            if (!got) check("rand_accept_timeout", 0, 1);
        end
        tlp_valid_i = 1'b0;
        p_ready_i = 1'b1; np_ready_i = 1'b1; cpl_ready_i = 1'b1;
        for (int w = 0; w < 100; w++) begin
            p_credit_ret_i   = (hs_cnt[0] > ret_cnt[0]);
            np_credit_ret_i  = (hs_cnt[1] > ret_cnt[1]);
            cpl_credit_ret_i = (hs_cnt[2] > ret_cnt[2]);
            if (p_credit_ret_i)   ret_cnt[0]++;
            if (np_credit_ret_i)  ret_cnt[1]++;
            if (cpl_credit_ret_i) ret_cnt[2]++;
            cyc();
        end
        p_credit_ret_i = 1'b0; np_credit_ret_i = 1'b0; cpl_credit_ret_i = 1'b0;
        sample();
        check("rand_credits", {p_credit_o, np_credit_o, cpl_credit_o}, {4'd8, 4'd8, 5'd16});
        check("rand_err", credit_err_o, 0);
        check("rand_sb_empty", sb.size(), 0);
        advance();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
